// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA host controller and its byte-wide register bus.
// No logic here: state encoding, register-select codes and operand geometry.
// Imported by the interface and the controller so both agree on field widths.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        GUARD,
        WAIT,
        RD_REQ,
        RD_CAP,
        RD_OUT
    } state_t;

    localparam logic [1:0] REG_RES = 2'd0;
    localparam logic [1:0] REG_M   = 2'd1;
    localparam logic [1:0] REG_E   = 2'd2;
    localparam logic [1:0] REG_N   = 2'd3;

    localparam int RSA_NBYTES = 32;
    localparam int RSA_AW     = 5;

endpackage

// File: rtl/rsa_host_ctrl_if.sv
// Byte streams in/out of the host controller plus the RSA register-bus pins and status.
// Pure wiring, no latency.
// Streams use valid/ready; the RSA bus side is strobe based with no stall input.
interface rsa_host_ctrl_if;
    import rsa_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              rsa_we;
    logic              rsa_oe;
    logic              rsa_start;
    logic [1:0]        rsa_reg_sel;
    logic [RSA_AW-1:0] rsa_addr;
    logic [7:0]        rsa_data_i;
    logic [7:0]        rsa_data_o;
    logic              rsa_ready;
    logic              busy;
    logic              done;
    logic              err;

    // Controller side
    modport master (
        input  in_valid, in_data, out_ready, rsa_data_o, rsa_ready,
        output in_ready, out_valid, out_data,
        output rsa_we, rsa_oe, rsa_start, rsa_reg_sel, rsa_addr, rsa_data_i,
        output busy, done, err
    );

    // Byte source/sink and RSA block side
    modport slave (
        output in_valid, in_data, out_ready, rsa_data_o, rsa_ready,
        input  in_ready, out_valid, out_data,
        input  rsa_we, rsa_oe, rsa_start, rsa_reg_sel, rsa_addr, rsa_data_i,
        input  busy, done, err
    );

endinterface

// File: rtl/rsa_host_ctrl.sv
// Host master for the RSA accelerator: loads M/e/N from a 96-byte stream, starts, reads back 32 result bytes.
// Latency: writes are combinational with the input handshake; 3 cycles minimum per result byte.
// Backpressure: in_valid gaps stall LOAD indefinitely; out_ready low holds RD_OUT with data stable.
module rsa_host_ctrl
    import rsa_pkg::*;
#(
    parameter int NBYTES      = RSA_NBYTES,
    parameter int START_GUARD = 2,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic           clk,
    input  logic           reset,
    rsa_host_ctrl_if.master bus
);

    localparam logic [RSA_AW-1:0] LAST_IDX   = RSA_AW'(NBYTES - 1);
    localparam logic [31:0]       GUARD_LAST = 32'(START_GUARD - 1);
    localparam logic [31:0]       TO_LAST    = 32'(TIMEOUT_CYC - 1);

    state_t            state;
    logic [RSA_AW-1:0] idx;
    logic [1:0]        sel;
    logic [31:0]       cnt;      // shared by the start guard and the completion timeout
    logic [7:0]        hold;
    logic              in_rdy_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic in_hs;
    logic rd_en;

    // in_rdy_q is only ever set while in IDLE/LOAD, so a handshake implies a write slot
    assign in_hs = bus.in_valid & in_rdy_q;
    assign rd_en = (state == RD_REQ);

    assign bus.in_ready    = in_rdy_q;
    assign bus.rsa_we      = in_hs;
    assign bus.rsa_oe      = rd_en;
    assign bus.rsa_start   = (state == START);
    assign bus.rsa_reg_sel = in_hs ? sel : REG_RES;
    assign bus.rsa_addr    = (in_hs | rd_en) ? idx : '0;
    assign bus.rsa_data_i  = in_hs ? bus.in_data : 8'h00;
    assign bus.out_valid   = (state == RD_OUT);
    assign bus.out_data    = hold;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

    // Sequencer: operand load, start/guard/wait, then byte-at-a-time result readback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            sel      <= REG_M;
            cnt      <= '0;
            hold     <= 8'h00;
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    in_rdy_q <= 1'b1;
                    if (in_hs) begin
                        busy_q <= 1'b1;
                        state  <= LOAD;
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (sel == REG_N) begin
                                sel      <= REG_M;
                                in_rdy_q <= 1'b0;
                                state    <= START;
                            end else begin
                                sel <= sel + 2'd1;
                            end
                        end else begin
                            idx <= idx + RSA_AW'(1);
                        end
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= (START_GUARD == 0) ? WAIT : GUARD;
                end
                GUARD: begin
                    // rsa_ready is ignored here: it may still show the pre-start idle level
                    if (cnt == GUARD_LAST) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT: begin
                    if (bus.rsa_ready) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= RD_REQ;
                    end else if (TIMEOUT_CYC != 0 && cnt == TO_LAST) begin
                        // Abandon the operation; operands must be reloaded
                        cnt      <= '0;
                        idx      <= '0;
                        sel      <= REG_M;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        in_rdy_q <= 1'b1;
                        state    <= IDLE;
                    end else if (TIMEOUT_CYC != 0) begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RD_REQ: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    // RSA read data is registered, so it becomes valid one cycle after oe
                    hold  <= bus.rsa_data_o;
                    state <= RD_OUT;
                end
                RD_OUT: begin
                    if (bus.out_ready) begin
                        if (idx == LAST_IDX) begin
                            idx      <= '0;
                            sel      <= REG_M;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            in_rdy_q <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            idx   <= idx + RSA_AW'(1);
                            state <= RD_REQ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
